// File: rtl/databus_mem_responder.sv
// Databus responder: serves valid/addr/len bursts from a single-port synchronous SRAM.
// Reads prefetch one word ahead so a continuously ready initiator sees one beat per cycle.
module databus_mem_responder #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned MEM_ADDR_W = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  databus_valid_i,
  output logic                  databus_ready_o,
  input  logic [AXI_ADDR_W-1:0] databus_addr_i,
  input  logic [LEN_W-1:0]      databus_len_i,
  input  logic                  databus_write_i,
  input  logic [DATA_W-1:0]     databus_wdata_i,
  output logic [DATA_W-1:0]     databus_rdata_o,
  output logic                  databus_last_o,
  input  logic                  stall_i,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  busy_o,
  output logic [15:0]           bursts_o
);

  localparam int unsigned BYTES    = DATA_W / 8;
  localparam int unsigned OFFSET_W = $clog2(BYTES);

  typedef enum logic [1:0] {StIdle, StWr, StRdFetch, StRdStream} state_e;

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] word_q, word_d;
  logic [LEN_W-1:0]      beats_q, beats_d;
  logic                  pending_q, pending_d;
  logic                  held_q, held_d;
  logic [DATA_W-1:0]     hold_q, hold_d;
  logic [15:0]           bursts_q, bursts_d;

  logic [LEN_W-1:0]      len_div;
  logic                  len_rem;
  logic [LEN_W-1:0]      req_beats;
  logic                  beat_avail;
  logic                  final_beat;
  logic                  unused_addr;

  // Address bits outside the word index are intentionally ignored.
  assign unused_addr = ^databus_addr_i;

  assign len_div = databus_len_i >> OFFSET_W;
  assign len_rem = |(databus_len_i & LEN_W'(BYTES - 1));

  // Round up to whole beats; a zero-length request still moves one beat.
  always_comb begin
    req_beats = len_div + LEN_W'(len_rem);
    if (req_beats == '0) begin
      req_beats = LEN_W'(1);
    end
  end

  // A read beat is available either straight off the SRAM or from the hold register.
  assign beat_avail = pending_q | held_q;
  assign final_beat = (beats_q == LEN_W'(1));

  always_comb begin
    state_d         = state_q;
    word_d          = word_q;
    beats_d         = beats_q;
    held_d          = held_q;
    bursts_d        = bursts_q;
    databus_ready_o = 1'b0;
    databus_last_o  = 1'b0;
    mem_en_o        = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;

    unique case (state_q)
      StIdle: begin
        if (databus_valid_i) begin
          word_d  = databus_addr_i[OFFSET_W +: MEM_ADDR_W];
          beats_d = req_beats;
          held_d  = 1'b0;
          state_d = databus_write_i ? StWr : StRdFetch;
        end
      end
      StWr: begin
        if (databus_valid_i && !stall_i) begin
          databus_ready_o = 1'b1;
          mem_en_o        = 1'b1;
          mem_we_o        = 1'b1;
          mem_addr_o      = word_q;
          word_d          = word_q + MEM_ADDR_W'(1);
          beats_d         = beats_q - LEN_W'(1);
          if (final_beat) begin
            databus_last_o = 1'b1;
            state_d        = StIdle;
          end
        end
      end
      StRdFetch: begin
        mem_en_o   = 1'b1;
        mem_addr_o = word_q;
        word_d     = word_q + MEM_ADDR_W'(1);
        state_d    = StRdStream;
      end
      StRdStream: begin
        if (databus_valid_i && !stall_i && beat_avail) begin
          databus_ready_o = 1'b1;
          beats_d         = beats_q - LEN_W'(1);
          held_d          = 1'b0;
          if (final_beat) begin
            databus_last_o = 1'b1;
            state_d        = StIdle;
          end else begin
            // Prefetch the next word on every accepted beat.
            mem_en_o   = 1'b1;
            mem_addr_o = word_q;
            word_d     = word_q + MEM_ADDR_W'(1);
          end
        end else if (pending_q) begin
          held_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (databus_ready_o && databus_last_o) begin
      bursts_d = bursts_q + 16'd1;
    end
  end

  assign pending_d = mem_en_o & ~mem_we_o;
  assign hold_d    = pending_q ? mem_rdata_i : hold_q;

  assign databus_rdata_o = pending_q ? mem_rdata_i : hold_q;
  assign mem_wdata_o     = databus_wdata_i;
  assign busy_o          = (state_q != StIdle);
  assign bursts_o        = bursts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      word_q    <= '0;
      beats_q   <= '0;
      pending_q <= 1'b0;
      held_q    <= 1'b0;
      hold_q    <= '0;
      bursts_q  <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      beats_q   <= beats_d;
      pending_q <= pending_d;
      held_q    <= held_d;
      hold_q    <= hold_d;
      bursts_q  <= bursts_d;
    end
  end

endmodule

// File: tb/tb_databus_mem_responder.sv
// Bench for databus_mem_responder: bench-owned SRAM, burst-level reference memory,
// randomized stalls/gaps and addresses.
module tb_databus_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] addr = '0;
  logic [7:0]  len = '0;
  logic        write = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        last;
  logic        stall = 1'b0;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [15:0] bursts;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wbuf [64];
  bit          init_done;

  int checks = 0;
  int failures = 0;
  int exp_bursts = 0;

  always #5 clk = ~clk;

  databus_mem_responder dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .databus_valid_i (valid),
    .databus_ready_o (ready),
    .databus_addr_i  (addr),
    .databus_len_i   (len),
    .databus_write_i (write),
    .databus_wdata_i (wdata),
    .databus_rdata_o (rdata),
    .databus_last_o  (last),
    .stall_i         (stall),
    .mem_en_o        (mem_en),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_rdata_i     (mem_rdata),
    .busy_o          (busy),
    .bursts_o        (bursts)
  );

  function automatic logic [31:0] init_word(input int unsigned i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  // Synchronous single-port SRAM; preloaded on the first clock during reset.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one burst as initiator; abort_at >= 0 leaves after that many beats with valid high.
  task automatic burst(input bit wr, input logic [31:0] a, input logic [7:0] l,
                       input int stall_pct, input int gap_pct, input int abort_at);
    int n, k, cyc, first, lastc, avail_from;
    logic [9:0] w0, w;
    n = (l == 8'd0) ? 1 : (int'(l) + 3) / 4;
    w0 = a[11:2];
    @(negedge clk);
    valid = 1'b1; write = wr; addr = a; len = l; stall = 1'b0; wdata = wbuf[0];
    @(posedge clk);
    k = 0; cyc = 0; first = -1; lastc = 0;
    avail_from = wr ? 1 : 2;
    while (k < n && cyc < 1000 && k != abort_at) begin
      @(negedge clk);
      cyc++;
      valid = ($urandom_range(99) >= gap_pct);
      stall = ($urandom_range(99) < stall_pct);
      wdata = wbuf[k];
      addr = $urandom; len = 8'($urandom); write = 1'($urandom);
      #1;
      w = w0 + 10'(k);
      if (cyc == 1) chk("busy_during", 32'(busy), 32'd1);
      if (!valid) chk("ready_without_valid", 32'(ready), 32'd0);
      if (ready) begin
        chk("last", 32'(last), 32'(k == n - 1));
        if (first < 0) first = cyc;
        lastc = cyc;
        if (wr) begin
          chk("wr_en", 32'({mem_en, mem_we}), 32'd3);
          chk("wr_addr", 32'(mem_addr), 32'(w));
          chk("wr_data", mem_wdata, wbuf[k]);
          ref_mem[w] = wbuf[k];
        end else begin
          chk("rd_data", rdata, ref_mem[w]);
          if (k == n - 1) chk("rd_no_overfetch", 32'(mem_en), 32'd0);
          else            chk("rd_prefetch", 32'({mem_en, mem_we}), 32'd2);
        end
        k++;
        avail_from = cyc + 1;
      end else begin
        chk("last_without_ready", 32'(last), 32'd0);
        if (!wr && cyc >= avail_from) chk("rd_hold", rdata, ref_mem[w]);
      end
    end
    if (k == abort_at) return;
    chk("beats_done", 32'(k), 32'(n));
    if (stall_pct == 0 && gap_pct == 0) begin
      chk("first_ready", 32'(first), wr ? 32'd1 : 32'd2);
      chk("back_to_back", 32'(lastc - first), 32'(n - 1));
    end
    @(negedge clk);
    valid = 1'b0; stall = 1'b0;
    exp_bursts++;
    #1;
    chk("busy_after", 32'(busy), 32'd0);
    chk("bursts", 32'(bursts), 32'(exp_bursts & 16'hFFFF));
  endtask

  initial begin
    int diffs;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_mem_en", 32'({mem_en, mem_we}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_bursts", 32'(bursts), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Words 16..19 hold 0..3, then read them back as one 4-beat burst.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i);
    burst(1'b1, 32'h40, 8'd16, 0, 0, -1);
    burst(1'b0, 32'h40, 8'd16, 0, 0, -1);

    wbuf[0] = 32'hA; wbuf[1] = 32'hB;
    burst(1'b1, 32'h100, 8'd8, 0, 0, -1);
    chk("mem64", mem[64], 32'hA);
    chk("mem65", mem[65], 32'hB);

    burst(1'b0, 32'h40, 8'd16, 40, 40, -1);
    burst(1'b0, 32'hFFC, 8'd8, 0, 0, -1);
    burst(1'b0, 32'h200, 8'd5, 0, 0, -1);
    burst(1'b0, 32'h204, 8'd0, 0, 0, -1);
    wbuf[0] = 32'h1234_5678;
    burst(1'b1, 32'h208, 8'd0, 0, 0, -1);

    // Reset in the middle of a 4-beat write, before beat index 2 transfers.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
    burst(1'b1, 32'h300, 8'd16, 0, 0, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bursts", 32'(bursts), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    exp_bursts = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    chk("abort_mem_w2", mem[194], ref_mem[194]);
    chk("abort_mem_w3", mem[195], ref_mem[195]);
    burst(1'b0, 32'h300, 8'd16, 0, 0, -1);

    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
      burst(1'($urandom), $urandom, 8'($urandom), 25, 25, -1);
    end

    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", 32'(diffs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
